// File: rtl/uart_fifo_ctl_if.sv
// Wishbone bus bundle between an SoC master and the uart_fifo_ctl register block.
interface uart_fifo_ctl_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic        wb_ack;
   logic [23:0] wb_adr;
   logic [15:0] wb_i_dat;
   logic [15:0] wb_o_dat;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
      input  wb_ack, wb_o_dat
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
      output wb_ack, wb_o_dat
   );
endinterface

// File: rtl/uart_fifo_ctl.sv
// Wishbone UART: programmable baud tick, RX/TX FIFOs, optional parity, sticky error flags
// and a maskable level interrupt, all in the i_clk domain.
module uart_fifo_ctl #(
   parameter int unsigned CLOCK_FREQ   = 25_000_000,
   parameter int unsigned BAUD_DEFAULT = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned FIFO_LOG     = 3
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           rx,
   output logic           tx,
   uart_fifo_ctl_if.slave wb,
   output logic           irq
);
   localparam int unsigned Depth = 2 ** FIFO_LOG;
   localparam int unsigned OsW   = $clog2(OVERSAMPLE);
   localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
   localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2 - 1);
   localparam logic [OsW-1:0] OsOne  = OsW'(1);
   localparam logic [FIFO_LOG:0] PtrOne = (FIFO_LOG + 1)'(1);
   localparam logic [15:0] DivDefault = 16'(CLOCK_FREQ / (BAUD_DEFAULT * OVERSAMPLE) - 1);

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

   // ---------------------------------------------------------------- bus decode
   logic bus_req, bus_wr, bus_rd;
   logic sel_status, sel_rxdata, sel_txdata, sel_ctrl, sel_div;

   assign bus_req    = wb.wb_cyc & wb.wb_stb;
   assign bus_wr     = bus_req & wb.wb_we;
   assign bus_rd     = bus_req & ~wb.wb_we;
   assign wb.wb_ack  = bus_req;
   assign sel_status = (wb.wb_adr == 24'd0);
   assign sel_rxdata = (wb.wb_adr == 24'd1);
   assign sel_txdata = (wb.wb_adr == 24'd2);
   assign sel_ctrl   = (wb.wb_adr == 24'd3);
   assign sel_div    = (wb.wb_adr == 24'd4);

   // ---------------------------------------------------------------- CTRL / DIV
   logic [4:0]  ctrl_q;
   logic [15:0] div_q;
   logic        rx_irq_en, tx_irq_en, par_en, par_odd, two_stop;

   assign rx_irq_en = ctrl_q[0];
   assign tx_irq_en = ctrl_q[1];
   assign par_en    = ctrl_q[3] ^ ctrl_q[2];
   assign par_odd   = ctrl_q[3];
   assign two_stop  = ctrl_q[4];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctrl_q <= '0;
         div_q  <= DivDefault;
      end else begin
         if (bus_wr && sel_ctrl) ctrl_q <= wb.wb_i_dat[4:0];
         if (bus_wr && sel_div)  div_q  <= wb.wb_i_dat;
      end
   end

   // ---------------------------------------------------------------- tick generator
   logic [15:0] tick_cnt_q;
   logic        os_tick;

   // >= keeps the counter bounded if it ever sits above a freshly lowered divisor
   assign os_tick = (tick_cnt_q >= div_q);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   tick_cnt_q <= '0;
      else if (bus_wr && sel_div)  tick_cnt_q <= '0;
      else if (os_tick)            tick_cnt_q <= '0;
      else                         tick_cnt_q <= tick_cnt_q + 16'd1;
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [7:0]        rx_mem [Depth];
   logic [FIFO_LOG:0] rx_wptr_q, rx_rptr_q;
   logic              rx_empty, rx_full, rx_push, rx_pop, rx_avail;
   logic [7:0]        rx_head, rx_shift_q;

   assign rx_empty = (rx_wptr_q == rx_rptr_q);
   assign rx_full  = (rx_wptr_q[FIFO_LOG-1:0] == rx_rptr_q[FIFO_LOG-1:0]) &&
                     (rx_wptr_q[FIFO_LOG] != rx_rptr_q[FIFO_LOG]);
   assign rx_avail = ~rx_empty;
   assign rx_head  = rx_mem[rx_rptr_q[FIFO_LOG-1:0]];
   assign rx_pop   = bus_rd & sel_rxdata & rx_avail;

   always_ff @(posedge i_clk) begin
      if (rx_push) rx_mem[rx_wptr_q[FIFO_LOG-1:0]] <= rx_shift_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
      end else begin
         if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
      end
   end

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]        tx_mem [Depth];
   logic [FIFO_LOG:0] tx_wptr_q, tx_rptr_q;
   logic              tx_empty, tx_full, tx_push, tx_pop;
   logic [7:0]        tx_head;

   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_wptr_q[FIFO_LOG-1:0] == tx_rptr_q[FIFO_LOG-1:0]) &&
                     (tx_wptr_q[FIFO_LOG] != tx_rptr_q[FIFO_LOG]);
   assign tx_head  = tx_mem[tx_rptr_q[FIFO_LOG-1:0]];
   assign tx_push  = bus_wr & sel_txdata & ~tx_full;

   always_ff @(posedge i_clk) begin
      if (tx_push) tx_mem[tx_wptr_q[FIFO_LOG-1:0]] <= wb.wb_i_dat[7:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
      end
   end

   // ---------------------------------------------------------------- RX path
   logic      rx_meta_q, rx_sync_q;
   rx_state_e rx_state_q, rx_state_d;
   logic [OsW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_shift_d;
   logic       rx_perr_q, rx_perr_d;
   logic       rx_done, set_frame_err, set_overrun, set_parity_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_perr_d     = rx_perr_q;
      rx_done       = 1'b0;
      set_frame_err = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (os_tick && !rx_sync_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (os_tick) begin
               if (rx_cnt_q == OsHalf) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_perr_d  = 1'b0;
                  rx_state_d = rx_sync_q ? RxIdle : RxData;
               end else begin
                  rx_cnt_d = rx_cnt_q + OsOne;
               end
            end
         end
         RxData: begin
            if (os_tick) begin
               if (rx_cnt_q == OsLast) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                  rx_bit_d   = rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_d = par_en ? RxParity : RxStop;
               end else begin
                  rx_cnt_d = rx_cnt_q + OsOne;
               end
            end
         end
         RxParity: begin
            if (os_tick) begin
               if (rx_cnt_q == OsLast) begin
                  rx_cnt_d   = '0;
                  rx_perr_d  = (rx_sync_q != (^rx_shift_q ^ par_odd));
                  rx_state_d = RxStop;
               end else begin
                  rx_cnt_d = rx_cnt_q + OsOne;
               end
            end
         end
         RxStop: begin
            if (os_tick) begin
               if (rx_cnt_q == OsLast) begin
                  rx_cnt_d      = '0;
                  rx_state_d    = RxIdle;
                  rx_done       = rx_sync_q;
                  set_frame_err = ~rx_sync_q;
               end else begin
                  rx_cnt_d = rx_cnt_q + OsOne;
               end
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign rx_push        = rx_done & ~rx_full;
   assign set_overrun    = rx_done & rx_full;
   assign set_parity_err = rx_done & rx_perr_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
      end
   end

   // ---------------------------------------------------------------- TX path
   tx_state_e tx_state_q, tx_state_d;
   logic [OsW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d, tx_bit_nxt;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       tx_q, tx_d, tx_idle;

   assign tx_bit_nxt = tx_bit_q + 3'd1;
   assign tx_idle    = tx_empty & (tx_state_q == TxIdle);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_byte_d  = tx_byte_q;
      tx_d       = tx_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            tx_d = 1'b1;
            // Leave IDLE on a tick so the start bit spans exactly OVERSAMPLE ticks
            if (os_tick && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_byte_d  = tx_head;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
               tx_d       = 1'b0;
            end
         end
         TxStart: begin
            if (os_tick) begin
               if (tx_cnt_q == OsLast) begin
                  tx_cnt_d   = '0;
                  tx_bit_d   = '0;
                  tx_state_d = TxData;
                  tx_d       = tx_byte_q[0];
               end else begin
                  tx_cnt_d = tx_cnt_q + OsOne;
               end
            end
         end
         TxData: begin
            if (os_tick) begin
               if (tx_cnt_q == OsLast) begin
                  tx_cnt_d = '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_bit_d = '0;
                     if (par_en) begin
                        tx_state_d = TxParity;
                        tx_d       = ^tx_byte_q ^ par_odd;
                     end else begin
                        tx_state_d = TxStop;
                        tx_d       = 1'b1;
                     end
                  end else begin
                     tx_bit_d = tx_bit_nxt;
                     tx_d     = tx_byte_q[tx_bit_nxt];
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q + OsOne;
               end
            end
         end
         TxParity: begin
            if (os_tick) begin
               if (tx_cnt_q == OsLast) begin
                  tx_cnt_d   = '0;
                  tx_bit_d   = '0;
                  tx_state_d = TxStop;
                  tx_d       = 1'b1;
               end else begin
                  tx_cnt_d = tx_cnt_q + OsOne;
               end
            end
         end
         TxStop: begin
            tx_d = 1'b1;
            if (os_tick) begin
               if (tx_cnt_q == OsLast) begin
                  tx_cnt_d = '0;
                  if (two_stop && tx_bit_q == 3'd0) tx_bit_d   = 3'd1;
                  else                              tx_state_d = TxIdle;
               end else begin
                  tx_cnt_d = tx_cnt_q + OsOne;
               end
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_byte_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_byte_q  <= tx_byte_d;
         tx_q       <= tx_d;
      end
   end

   assign tx = tx_q;

   // ---------------------------------------------------------------- status, irq
   logic overrun_q, frame_err_q, parity_err_q, irq_q, status_wr;

   assign status_wr = bus_wr & sel_status;

   // A new error event wins over a same-cycle software clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         if (set_overrun)                          overrun_q    <= 1'b1;
         else if (status_wr && wb.wb_i_dat[3])     overrun_q    <= 1'b0;
         if (set_frame_err)                        frame_err_q  <= 1'b1;
         else if (status_wr && wb.wb_i_dat[4])     frame_err_q  <= 1'b0;
         if (set_parity_err)                       parity_err_q <= 1'b1;
         else if (status_wr && wb.wb_i_dat[5])     parity_err_q <= 1'b0;
         irq_q <= (rx_irq_en & rx_avail) | (tx_irq_en & tx_idle);
      end
   end

   assign irq = irq_q;

   logic [15:0] rd_data;

   always_comb begin
      rd_data = '0;
      if (sel_status) begin
         rd_data = {10'b0, parity_err_q, frame_err_q, overrun_q, tx_idle, ~tx_full, rx_avail};
      end else if (sel_rxdata) begin
         rd_data = rx_avail ? {8'b0, rx_head} : 16'h0000;
      end else if (sel_ctrl) begin
         rd_data = {11'b0, ctrl_q};
      end else if (sel_div) begin
         rd_data = div_q;
      end
   end

   assign wb.wb_o_dat = rd_data;
endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Randomised self-checking bench for uart_fifo_ctl against a queue-based UART model.
module tb_uart_fifo_ctl;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic rx_drv = 1'b1;
   logic loop_en = 1'b0;
   logic rx, tx, irq;

   always #5 i_clk = ~i_clk;
   assign rx = loop_en ? tx : rx_drv;

   uart_fifo_ctl_if bus ();

   uart_fifo_ctl #(
      .CLOCK_FREQ  (25_000_000),
      .BAUD_DEFAULT(115200),
      .OVERSAMPLE  (16),
      .FIFO_LOG    (3)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .rx   (rx),
      .tx   (tx),
      .wb   (bus),
      .irq  (irq)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: RX FIFO contents and sticky flags
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit m_ovr, m_frm, m_par;

   logic [15:0] rd;
   logic [7:0]  b, cap;
   bit          seen;
   logic        stop_bit;
   int          n, pm, ts, nframes, w;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_status();
      return {10'b0, m_par, m_frm, m_ovr, 1'b1, 1'b1, rxq.size() != 0};
   endfunction

   function automatic logic par_bit(input logic [7:0] v, input int mode);
      return ^v ^ (mode == 2);
   endfunction

   task automatic model_rx(input logic [7:0] v, input bit stop_ok, input bit par_ok);
      if (!stop_ok) m_frm = 1'b1;
      else begin
         if (!par_ok) m_par = 1'b1;
         if (rxq.size() == 8) m_ovr = 1'b1;
         else rxq.push_back(v);
      end
   endtask

   task automatic idle(input int cyc);
      repeat (cyc) @(posedge i_clk);
      #1;
   endtask

   task automatic bus_write(input logic [23:0] adr, input logic [15:0] dat);
      bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
      bus.wb_adr = adr;  bus.wb_i_dat = dat;
      @(posedge i_clk); #1;
      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
   endtask

   task automatic bus_read(input logic [23:0] adr, output logic [15:0] dat);
      bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_adr = adr;
      @(negedge i_clk);
      dat = bus.wb_o_dat;
      @(posedge i_clk); #1;
      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
   endtask

   task automatic wait_tx_idle(input int budget);
      logic [15:0] st;
      int k = 0;
      st = 16'h0;
      while (!st[2] && k < budget) begin
         bus_read(24'd0, st);
         k++;
      end
      if (!st[2]) check("tx_idle_timeout", 32'(st[2]), 32'd1);
   endtask

   // Drive one serial frame onto rx; mode 0 none, 1 even, 2 odd
   task automatic send_frame(input logic [7:0] v, input int mode, input bit flip_par,
                             input logic stop_val, input int bc);
      rx_drv = 1'b0; idle(bc);
      for (int i = 0; i < 8; i++) begin
         rx_drv = v[i]; idle(bc);
      end
      if (mode == 1 || mode == 2) begin
         rx_drv = par_bit(v, mode) ^ flip_par; idle(bc);
      end
      rx_drv = stop_val; idle(bc);
      rx_drv = 1'b1; idle(bc);
   endtask

   // Decode one frame from tx, sampling mid-bit; returns at mid stop bit
   task automatic cap_frame(input int bc, input int budget, output logic [7:0] v,
                            output bit got, output logic stop_v);
      int k = 0;
      v = 8'h0; got = 1'b0; stop_v = 1'b0;
      @(negedge i_clk);
      while (tx !== 1'b0 && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      if (tx === 1'b0) begin
         got = 1'b1;
         repeat (bc / 2) @(negedge i_clk);
         for (int i = 0; i < 8; i++) begin
            repeat (bc) @(negedge i_clk);
            v[i] = tx;
         end
         repeat (bc) @(negedge i_clk);
         stop_v = tx;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
      bus.wb_adr = '0;   bus.wb_i_dat = '0;
      m_ovr = 0; m_frm = 0; m_par = 0;
      idle(3);
      i_rst = 1'b0;
      idle(2);

      // Reset state
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      bus_read(24'd0, rd); check("rst_status", 32'(rd), 32'h6);
      bus_read(24'd3, rd); check("rst_ctrl", 32'(rd), 32'h0);
      bus_read(24'd4, rd); check("rst_div", 32'(rd), 32'd12);
      bus_read(24'd1, rd); check("rst_rxdata", 32'(rd), 32'h0);
      bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_adr = 24'd7;
      @(negedge i_clk);
      check("ack_on", 32'(bus.wb_ack), 32'd1);
      check("unmapped_rd", 32'(bus.wb_o_dat), 32'h0);
      @(posedge i_clk); #1;
      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
      @(negedge i_clk);
      check("ack_off", 32'(bus.wb_ack), 32'd0);
      idle(1);
      bus_write(24'd9, 16'hFFFF);
      bus_read(24'd3, rd); check("unmapped_wr_ctrl", 32'(rd), 32'h0);

      // TX 0x55 at default divisor: 208 cycles per bit
      b = 8'h55;
      bus_write(24'd2, {8'h00, b});
      w = 0;
      while (tx !== 1'b0 && w < 100) begin @(negedge i_clk); w++; end
      check("tx55_start_seen", 32'(tx), 32'd0);
      n = 0;
      while (tx === 1'b0 && n < 400) begin n++; @(negedge i_clk); end
      check("tx55_start_len", 32'(n), 32'd208);
      repeat (104) @(negedge i_clk);
      check("tx55_bit0", 32'(tx), 32'(b[0]));
      for (int i = 1; i < 8; i++) begin
         repeat (208) @(negedge i_clk);
         check($sformatf("tx55_bit%0d", i), 32'(tx), 32'(b[i]));
      end
      repeat (208) @(negedge i_clk);
      check("tx55_stop", 32'(tx), 32'd1);
      idle(120);
      bus_read(24'd0, rd); check("tx55_idle_status", 32'(rd), 32'h6);

      // Loopback with randomised parity / stop bits, DIV=0
      bus_write(24'd4, 16'd0);
      loop_en = 1'b1;
      idle(4);
      for (int r = 0; r < 4; r++) begin
         pm = (r == 0) ? 1 : int'($urandom_range(0, 3));
         ts = (r == 0) ? 0 : int'($urandom_range(0, 1));
         n  = (r == 0) ? 2 : int'($urandom_range(1, 4));
         bus_write(24'd3, 16'(ts * 16 + pm * 4));
         for (int i = 0; i < n; i++) begin
            b = (r == 0) ? ((i == 0) ? 8'hA5 : 8'h3C) : 8'($urandom);
            bus_write(24'd2, {8'h00, b});
            model_rx(b, 1'b1, 1'b1);
         end
         wait_tx_idle(3000);
         idle(8);
         bus_read(24'd0, rd); check($sformatf("loop%0d_status", r), 32'(rd), 32'(exp_status()));
         for (int i = 0; i < n; i++) begin
            bus_read(24'd1, rd);
            check($sformatf("loop%0d_byte%0d", r, i), 32'(rd), 32'(rxq.pop_front()));
         end
         bus_read(24'd1, rd); check($sformatf("loop%0d_empty_rd", r), 32'(rd), 32'h0);
         bus_read(24'd0, rd); check($sformatf("loop%0d_status_end", r), 32'(rd), 32'(exp_status()));
      end
      loop_en = 1'b0;
      bus_write(24'd3, 16'h0);
      idle(4);

      // Overrun: 9 frames with no reads
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, 1'b0, 1'b1, 16);
         model_rx(b, 1'b1, 1'b1);
      end
      idle(4);
      bus_read(24'd0, rd); check("ovr_status", 32'(rd), 32'(exp_status()));
      for (int i = 0; i < 8; i++) begin
         bus_read(24'd1, rd);
         check($sformatf("ovr_byte%0d", i), 32'(rd), 32'(rxq.pop_front()));
      end
      bus_write(24'd0, 16'h0008); m_ovr = 1'b0;
      bus_read(24'd0, rd); check("ovr_cleared", 32'(rd), 32'(exp_status()));

      // Parity error: byte kept, flag set
      bus_write(24'd3, 16'h0004);
      b = 8'($urandom);
      send_frame(b, 1, 1'b1, 1'b1, 16);
      model_rx(b, 1'b1, 1'b0);
      idle(4);
      bus_read(24'd0, rd); check("perr_status", 32'(rd), 32'(exp_status()));
      bus_read(24'd1, rd); check("perr_byte", 32'(rd), 32'(rxq.pop_front()));
      bus_write(24'd0, 16'h0020); m_par = 1'b0;
      bus_read(24'd0, rd); check("perr_cleared", 32'(rd), 32'(exp_status()));
      bus_write(24'd3, 16'h0000);

      // Frame error: stop bit low, byte discarded
      b = 8'($urandom);
      send_frame(b, 0, 1'b0, 1'b0, 16);
      model_rx(b, 1'b0, 1'b1);
      idle(40);
      bus_read(24'd0, rd); check("ferr_status", 32'(rd), 32'(exp_status()));
      bus_write(24'd0, 16'h0010); m_frm = 1'b0;
      bus_read(24'd0, rd); check("ferr_cleared", 32'(rd), 32'(exp_status()));

      // 4-cycle glitch is rejected; a following frame is received normally
      rx_drv = 1'b0; idle(4); rx_drv = 1'b1; idle(60);
      bus_read(24'd0, rd); check("glitch_status", 32'(rd), 32'(exp_status()));
      b = 8'($urandom);
      send_frame(b, 0, 1'b0, 1'b1, 16);
      model_rx(b, 1'b1, 1'b1);
      idle(2);
      bus_read(24'd1, rd); check("post_glitch_byte", 32'(rd), 32'(rxq.pop_front()));

      // TX FIFO full: DIV write reloads the tick so no pop occurs during the burst
      bus_write(24'd4, 16'd12);
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         bus_write(24'd2, {8'h00, b});
         txq.push_back(b);
      end
      bus_read(24'd0, rd); check("txfull_not_full", 32'(rd[1]), 32'd0);
      bus_write(24'd2, 16'h00EE);
      nframes = 0;
      for (int i = 0; i < 9; i++) begin
         cap_frame(208, (i == 8) ? 3000 : 600, cap, seen, stop_bit);
         if (seen) begin
            nframes++;
            if (txq.size() != 0) begin
               check($sformatf("txfull_frame%0d", i), 32'(cap), 32'(txq.pop_front()));
               check($sformatf("txfull_stop%0d", i), 32'(stop_bit), 32'd1);
            end
         end
      end
      check("txfull_frames", 32'(nframes), 32'd8);
      idle(1);
      bus_read(24'd0, rd); check("txfull_status_end", 32'(rd), 32'(exp_status()));

      // Interrupt behaviour
      bus_write(24'd4, 16'd0);
      bus_write(24'd3, 16'h0003);
      idle(2);
      check("irq_tx_idle", 32'(irq), 32'd1);
      bus_write(24'd3, 16'h0001);
      idle(2);
      check("irq_masked", 32'(irq), 32'd0);
      b = 8'($urandom);
      send_frame(b, 0, 1'b0, 1'b1, 16);
      model_rx(b, 1'b1, 1'b1);
      idle(2);
      check("irq_rx", 32'(irq), 32'd1);
      bus_read(24'd1, rd); check("irq_rx_byte", 32'(rd), 32'(rxq.pop_front()));
      check("irq_lag", 32'(irq), 32'd1);
      idle(1);
      check("irq_cleared", 32'(irq), 32'd0);

      // Asynchronous reset in the middle of a TX frame
      bus_write(24'd3, 16'h0000);
      bus_write(24'd2, 16'h0000);
      w = 0;
      while (tx !== 1'b0 && w < 100) begin @(negedge i_clk); w++; end
      check("rst_mid_start_seen", 32'(tx), 32'd0);
      idle(40);
      @(posedge i_clk); #2;
      i_rst = 1'b1;
      #1;
      check("rst_mid_tx", 32'(tx), 32'd1);
      rxq.delete(); m_ovr = 0; m_frm = 0; m_par = 0;
      idle(2);
      i_rst = 1'b0;
      idle(1);
      bus_read(24'd0, rd); check("rst_mid_status", 32'(rd), 32'h6);
      bus_read(24'd4, rd); check("rst_mid_div", 32'(rd), 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_fifo_ctl.md
Name: uart_fifo_ctl

Overview:
Parametrised second-generation Wishbone UART peripheral for the SoC bus, running entirely in the i_clk domain with clock-enable ticks instead of derived clocks. It provides a runtime-programmable baud divisor, parameterised RX/TX FIFO depth, optional parity and two stop bits, and sticky error flags. A single maskable level interrupt is exported to the interrupt controller.

Parameters:
CLOCK_FREQ, 25_000_000, i_clk frequency in Hz.
BAUD_DEFAULT, 115200, baud rate selected after reset.
OVERSAMPLE, 16, RX samples per bit; power of two, at least 8.
FIFO_LOG, 3, log2 of RX and TX FIFO depth (depth = 2**FIFO_LOG entries, all usable).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  reset, asynchronous, active-high.
rx  in  1  serial input, idle high, asynchronous to i_clk.
tx  out  1  serial output, idle high.
wb_cyc  in  1  Wishbone cycle.
wb_stb  in  1  Wishbone strobe.
wb_we  in  1  Wishbone write enable.
wb_ack  out  1  Wishbone acknowledge.
wb_adr  in  24  word address.
wb_i_dat  in  16  write data.
wb_o_dat  out  16  read data.
irq  out  1  level interrupt request.

Behaviour:
- Reset values: tx=1, irq=0, both FIFOs empty, CTRL=0, DIV=CLOCK_FREQ/(BAUD_DEFAULT*OVERSAMPLE)-1 (integer division), all error flags 0, both FSMs in IDLE.
- Bus: wb_ack = wb_cyc & wb_stb (combinational, zero wait). wb_o_dat is combinational from wb_adr. Side effects occur once per cycle in which wb_cyc & wb_stb is high.
- Register map (word addresses):
  0 STATUS, read: bit0 rx_avail; bit1 tx_not_full; bit2 tx_idle (TX FIFO empty and TX FSM in IDLE); bit3 overrun; bit4 frame_err; bit5 parity_err. Write: a 1 clears the corresponding bit in bits 3-5.
  1 RXDATA, read: {8'b0, head byte}. The read pops the FIFO only if rx_avail=1. A read when empty returns 0 and has no effect.
  2 TXDATA, write: pushes wb_i_dat[7:0]. A write when full is dropped; no flag is set.
  3 CTRL, read/write: bit0 rx_irq_en; bit1 tx_irq_en; bits3:2 parity (00 none, 01 even, 10 odd, 11 treated as none); bit4 two stop bits.
  4 DIV, read/write, 16 bit. A write reloads the tick counter to 0.
  Other addresses: read 0, write ignored, still acked.
- Tick generator: a counter counts 0..DIV. It emits a one-cycle os_tick when it wraps. Bit period = OVERSAMPLE os_ticks.
- RX path:
  - rx passes through a 2-flop synchroniser before use.
  - FSM states: IDLE -> START on a sampled low at an os_tick.
  - START: counts OVERSAMPLE/2 ticks. If the line is high at mid-bit, the start is a glitch and the FSM returns to IDLE. Otherwise it goes to DATA.
  - DATA: samples 8 bits LSB-first, one every OVERSAMPLE ticks.
  - PARITY: entered only when parity is enabled; the mismatch is held pending.
  - STOP: samples one stop bit only; the second stop bit is ignored on RX. A low stop bit sets frame_err and the byte is discarded.
  - On a valid stop bit the byte is pushed. If the RX FIFO is full, the byte is dropped and overrun is set. A parity mismatch sets parity_err but the byte is still pushed.
  - After STOP the FSM returns to IDLE.
- TX path:
  - FSM states: IDLE -> START when the FIFO is non-empty. The pop and latch into the shifter happen in the same cycle.
  - START (low) -> DATA (8 bits LSB-first) -> PARITY (if enabled) -> STOP (high; 1 or 2 bit periods per CTRL bit4) -> IDLE.
  - Each state lasts exactly OVERSAMPLE os_ticks. tx is driven from a register.
  - CTRL and DIV changes mid-frame take effect immediately. Software must wait for tx_idle before changing them.
- FIFOs: pointers are FIFO_LOG+1 bits wide with a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ. A push and a pop in the same cycle both occur.
- irq = (rx_irq_en & rx_avail) | (tx_irq_en & tx_idle), registered with 1 cycle latency.
- Reset mid-frame: tx returns to 1 immediately, asynchronously. The partial RX frame is discarded.

Test Plan:
- Reset with DIV default 12: write 0x55 to addr 2 -> tx low for 208 cycles, then bits 1,0,1,0,1,0,1,0 at 208 cycles each, then high; STATUS bit2 returns to 1 afterwards.
- Loopback rx=tx, DIV=0, CTRL parity=even: push 0xA5, 0x3C -> RXDATA reads 0xA5 then 0x3C; STATUS bits 3-5 = 0; a third read returns 0 with rx_avail=0.
- Drive 9 frames into rx with no reads (FIFO_LOG=3) -> 8 bytes stored in order, overrun=1; writing 0x0008 to STATUS clears it.
- Frame with stop bit 0 -> frame_err=1, rx_avail stays 0. 4-cycle low glitch on rx (DIV=0) -> no reception, FSM back in IDLE.
- Push 9 bytes back-to-back -> 9th dropped, tx_not_full=0 after the 8th write, and exactly 8 frames are transmitted.
- CTRL=0x3 with empty FIFOs -> irq=1 from tx_idle; set CTRL=0x1 -> irq=0; receive 1 byte -> irq=1; read it -> irq=0 one cycle later. Assert i_rst mid-TX frame -> tx=1 within the same cycle.
